imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction memory that sits directly upstream of the single-cycle CPU core. It drives the core's `instruction` input from the core's `read_address` output.
- Holds up to DEPTH 8-bit instructions, written by an external byte stream through a valid/ready load port.
- Holds the core in reset while no complete program is present or a load is in progress. Once a load completes, it serves reads combinationally, so a fetch completes in the core's cycle.

Parameters:
- DEPTH, 256, number of instruction slots; must equal 2**ADDR_W.
- ADDR_W, 8, address width; matches the core's read_address.
- NOP_INSTR, 8'h00, value returned for any address at or beyond the loaded program length.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a new program load.
- load_valid  in  1  load_data holds a byte to be written.
- load_data  in  8  instruction byte.
- load_last  in  1  qualifies the current byte as the final byte of the program.
- load_ready  out  1  block accepts a byte this cycle.
- read_address  in  ADDR_W  fetch address from the core's PC.
- instruction  out  8  fetched instruction to the core.
- cpu_clear  out  1  reset to the core; high while no valid program is present.
- loading  out  1  high while in LOAD.
- prog_len  out  ADDR_W+1  number of bytes in the current program (0..DEPTH).

Behaviour:
- State machine: IDLE, LOAD, RUN, encoded in a register.
- Reset (clear=1, asynchronous): state=IDLE, wr_ptr=0, prog_len=0, cpu_clear=1, loading=0, load_ready=0.
  - Memory array contents are not reset.
  - With prog_len=0, instruction=NOP_INSTR for every address.
- Registered outputs: loading and cpu_clear are registered. load_ready = (state==LOAD).
- Byte acceptance: a byte is accepted on a rising edge when load_valid && load_ready. The accepted byte is written to mem[wr_ptr] and wr_ptr increments.
- IDLE:
  - cpu_clear=1.
  - load_start -> LOAD on the next edge, with wr_ptr cleared to 0 and prog_len cleared to 0.
- LOAD:
  - cpu_clear=1, loading=1.
  - An accepted byte with load_last=1 ends the load: prog_len=wr_ptr+1, then go to RUN.
  - An accepted byte at wr_ptr=DEPTH-1 ends the load regardless of load_last: prog_len=DEPTH, then go to RUN.
  - load_start in LOAD restarts the load: wr_ptr=0, any partial bytes are discarded, and no byte is accepted that edge even if load_valid=1. load_start has priority over acceptance.
  - load_last without load_valid is ignored.
- RUN:
  - cpu_clear=0; it falls on the same edge that enters RUN.
  - instruction = mem[read_address] when read_address < prog_len, otherwise NOP_INSTR. The read is purely combinational, with no latency.
  - load_start -> LOAD: cpu_clear=1 and prog_len=0 on that edge, so the core is reset before any byte is overwritten.
- Outside RUN, instruction=NOP_INSTR.
- load_valid while load_ready=0 is ignored: no write, no pointer change. The source must hold the byte until it sees ready.
- Reset mid-load: the FSM returns to IDLE, prog_len=0, and the core is held in reset. Partially written memory is never served.
- Width rules:
  - wr_ptr is ADDR_W+1 bits.
  - prog_len reaches DEPTH without wrapping.
  - read_address is compared as an unsigned value against prog_len.

Test Plan:
- Reset then idle: assert clear, release -> cpu_clear=1, load_ready=0, prog_len=0, instruction=8'h00 for read_address 8'h00 and 8'hFF.
- Basic load: load_start, then bytes 8'h41, 8'h82, 8'hC3 with load_last on the third -> prog_len=3, cpu_clear=0 on the same edge. read_address 0/1/2 gives 41/82/C3; read_address 3 gives 8'h00.
- Backpressure and gaps: during LOAD, toggle load_valid with idle cycles between bytes; drive load_valid=1 in IDLE before load_start -> only the bytes given while ready are written, and the IDLE byte is never stored.
- Full memory: stream 256 bytes 8'h00..8'hFF without load_last -> RUN after the 256th byte, prog_len=256, mem[8'hFF]=8'hFF.
- Restart mid-load: after 2 bytes, assert load_start together with load_valid -> that byte is not written. Load 8'h11 with last -> prog_len=1, address 1 returns NOP.
- Reload from RUN and async reset: in RUN, assert load_start -> cpu_clear=1 on the same edge, prog_len=0. Mid-load, assert clear between edges -> state=IDLE immediately and cpu_clear=1.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loaded instruction memory that gates the core's reset
// Serves reads combinationally in RUN; holds the core in reset until a complete program is loaded.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  NOP_INSTR = 8'h00
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] read_address,
  output logic [7:0]        instruction,
  output logic              cpu_clear,
  output logic              loading,
  output logic [ADDR_W:0]   prog_len
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]      state;
  logic [ADDR_W:0] wr_ptr;
  logic [7:0]      mem [DEPTH];
  logic            accept;
  logic            load_done;

  assign load_ready = (state == ST_LOAD);
  // load_start wins over a byte presented on the same edge
  assign accept     = load_ready && load_valid && !load_start;
  assign load_done  = accept && (load_last || (wr_ptr == LAST_PTR));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      prog_len  <= '0;
      cpu_clear <= 1'b1;
      loading   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_clear <= 1'b1;
          if (load_start) begin
            state    <= ST_LOAD;
            wr_ptr   <= '0;
            prog_len <= '0;
            loading  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            wr_ptr <= '0;
          end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (load_done) begin
              prog_len  <= wr_ptr + 1'b1;
              state     <= ST_RUN;
              cpu_clear <= 1'b0;
              loading   <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          // core goes back into reset before any byte can be overwritten
          if (load_start) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            prog_len  <= '0;
            cpu_clear <= 1'b1;
            loading   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          wr_ptr    <= '0;
          prog_len  <= '0;
          cpu_clear <= 1'b1;
          loading   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= load_data;
    end
  end

  always_comb begin
    instruction = NOP_INSTR;
    if ((state == ST_RUN) && ({1'b0, read_address} < prog_len)) begin
      instruction = mem[read_address];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic       clock;
  logic       clear;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic       cpu_clear;
  logic       loading;
  logic [8:0] prog_len;

  imem_loader #(.DEPTH(256), .ADDR_W(8), .NOP_INSTR(8'h00)) dut (
    .clock        (clock),
    .clear        (clear),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .read_address (read_address),
    .instruction  (instruction),
    .cpu_clear    (cpu_clear),
    .loading      (loading),
    .prog_len     (prog_len)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: program held as a byte list; only a completed load becomes visible.
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  int         m_phase;
  logic [7:0] m_buf[$];
  logic [7:0] m_prog[$];

  typedef struct {
    logic       s;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [7:0] a;
    logic       ready;
    logic       cclr;
    int         len;
    logic [7:0] instr;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_buf.delete();
    m_prog.delete();
  endtask

  task automatic model_step(input logic s, input logic v, input logic [7:0] d, input logic l);
    case (m_phase)
      P_IDLE: if (s) begin
        m_phase = P_LOAD;
        m_buf.delete();
      end
      P_LOAD: begin
        if (s) begin
          m_buf.delete();
        end else if (v) begin
          m_buf.push_back(d);
          if (l || m_buf.size() == 256) begin
            m_prog  = m_buf;
            m_phase = P_RUN;
          end
        end
      end
      default: if (s) begin
        m_phase = P_LOAD;
        m_buf.delete();
        m_prog.delete();
      end
    endcase
  endtask

  function automatic int exp_instr(input logic [7:0] a);
    if (m_phase == P_RUN && int'(a) < m_prog.size()) return int'(m_prog[a]);
    return 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".load_ready"}, int'(load_ready), int'(m_phase == P_LOAD));
    chk({tag, ".loading"},    int'(loading),    int'(m_phase == P_LOAD));
    chk({tag, ".cpu_clear"},  int'(cpu_clear),  int'(m_phase != P_RUN));
    chk({tag, ".prog_len"},   int'(prog_len),   m_prog.size());
    chk({tag, ".instruction"}, int'(instruction), exp_instr(read_address));
  endtask

  task automatic cycle(input logic s, input logic v, input logic [7:0] d,
                       input logic l, input logic [7:0] a, input string tag);
    load_start   = s;
    load_valid   = v;
    load_data    = d;
    load_last    = l;
    read_address = a;
    @(posedge clock);
    model_step(s, v, d, l);
    #1;
    check_all(tag);
  endtask

  task automatic peek(input logic [7:0] a, input int exp, input string tag);
    read_address = a;
    #1;
    chk(tag, int'(instruction), exp);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 8'h82, 1'b0, 8'h01, 1'b1, 1'b1, 0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 8'h55, 1'b1, 8'h00, 1'b1, 1'b1, 0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 8'h00, 1'b0, 1'b0, 3, 8'h41};
    tbl[7]  = '{1'b0, 1'b1, 8'h99, 1'b0, 8'h01, 1'b0, 1'b0, 3, 8'h82};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0, 3, 8'hC3};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 3, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 3, 8'h00};

    clear = 1'b1;
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    read_address = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    chk("reset.cpu_clear", int'(cpu_clear), 1);
    chk("reset.load_ready", int'(load_ready), 0);
    chk("reset.prog_len", int'(prog_len), 0);
    peek(8'h00, 0, "reset.instr00");
    peek(8'hFF, 0, "reset.instrFF");

    // basic load with gaps and an ignored IDLE byte
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].a, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.ready", i), int'(load_ready), int'(tbl[i].ready));
      chk($sformatf("tbl%0d.cpu_clear", i), int'(cpu_clear), int'(tbl[i].cclr));
      chk($sformatf("tbl%0d.prog_len", i), int'(prog_len), tbl[i].len);
      chk($sformatf("tbl%0d.instr", i), int'(instruction), int'(tbl[i].instr));
    end

    // reload from RUN: core reset on the same edge
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "reload");
    chk("reload.cpu_clear", int'(cpu_clear), 1);
    chk("reload.prog_len", int'(prog_len), 0);
    chk("reload.instr", int'(instruction), 0);

    // full memory without load_last
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0, 8'hFF, "full");
      if (i == 254) chk("full.pre_cpu_clear", int'(cpu_clear), 1);
    end
    chk("full.prog_len", int'(prog_len), 256);
    chk("full.cpu_clear", int'(cpu_clear), 0);
    peek(8'hFF, 8'hFF, "full.instrFF");
    peek(8'h80, 8'h80, "full.instr80");

    // restart mid-load; the byte presented with load_start is dropped
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "rs.start");
    cycle(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, "rs.b0");
    cycle(1'b0, 1'b1, 8'h5B, 1'b0, 8'h00, "rs.b1");
    cycle(1'b1, 1'b1, 8'h99, 1'b0, 8'h00, "rs.restart");
    cycle(1'b0, 1'b1, 8'h11, 1'b1, 8'h00, "rs.last");
    chk("rs.prog_len", int'(prog_len), 1);
    peek(8'h00, 8'h11, "rs.instr0");
    peek(8'h01, 8'h00, "rs.instr1");

    // async reset between edges in the middle of a load
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "ar.start");
    cycle(1'b0, 1'b1, 8'h21, 1'b0, 8'h00, "ar.b0");
    clear = 1'b1;
    #1;
    model_reset();
    chk("ar.cpu_clear", int'(cpu_clear), 1);
    chk("ar.load_ready", int'(load_ready), 0);
    chk("ar.loading", int'(loading), 0);
    chk("ar.prog_len", int'(prog_len), 0);
    #1;
    clear = 1'b0;
    cycle(1'b0, 1'b1, 8'h22, 1'b1, 8'h00, "ar.after");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic       s, v, l;
      logic [7:0] d, a;
      s = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 6);
      l = ($urandom_range(0, 11) == 0);
      d = 8'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      cycle(s, v, d, l, a, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
